// File: rtl/sobel_line_sched.sv
// sobel_line_sched: steers camera pixels into three rotating line buffers and flags
// when a full 3x3 Sobel window is available around the newest pixel.
module sobel_line_sched #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] fvh,
  input  logic       dv,
  input  logic [7:0] pixel_in,
  output logic [2:0] lb_we,
  output logic [9:0] lb_addr,
  output logic [7:0] lb_wdata,
  output logic [1:0] top_sel,
  output logic       win_valid,
  output logic [9:0] win_col,
  output logic [8:0] win_row,
  output logic       frame_done,
  output logic [1:0] state_o
);
  typedef enum logic [1:0] {WAIT_VS = 2'd0, FILL = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
  localparam logic [9:0] W = 10'(WIDTH);
  localparam logic [8:0] H = 9'(HEIGHT);
  state_t     state;
  logic [2:0] old_fvh, wr_sel, rise;
  logic [9:0] col;
  logic [8:0] row;
  logic       line_has, vfall, accept;
  assign rise    = fvh & ~old_fvh;
  assign vfall   = old_fvh[2] & ~fvh[2];
  assign accept  = dv && fvh == 3'b000 && (state == FILL || state == RUN) && col < W && row < H;
  assign state_o = state;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_VS;
      old_fvh    <= 3'b111;
      wr_sel     <= 3'b001;
      top_sel    <= 2'd1;
      col        <= '0;
      row        <= '0;
      line_has   <= 1'b0;
      lb_we      <= '0;
      lb_addr    <= '0;
      lb_wdata   <= '0;
      win_valid  <= 1'b0;
      win_col    <= '0;
      win_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      old_fvh    <= fvh;
      frame_done <= 1'b0;
      lb_we      <= accept ? wr_sel : 3'b000;
      lb_addr    <= col;
      lb_wdata   <= pixel_in;
      win_valid  <= accept && state == RUN && col >= 10'd2;
      if (accept) begin
        win_col  <= col;
        win_row  <= row;
        col      <= col + 10'd1;
        line_has <= 1'b1;
      end
      case (state)
        WAIT_VS: begin
          col      <= '0;
          row      <= '0;
          line_has <= 1'b0;
          if (vfall) state <= FILL;
        end
        FILL, RUN: begin
          // Empty lines (blanking, dropped lines) must not advance the buffer ring.
          if (rise[0]) begin
            col      <= '0;
            line_has <= 1'b0;
            if (line_has) begin
              wr_sel  <= {wr_sel[1:0], wr_sel[2]};
              top_sel <= top_sel == 2'd2 ? 2'd0 : top_sel + 2'd1;
              if (row < H) row <= row + 9'd1;
              if (state == FILL && row == 9'd1) state <= RUN;
            end
          end
          if (rise[2]) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        default: begin
          col      <= '0;
          row      <= '0;
          line_has <= 1'b0;
          state    <= WAIT_VS;
        end
      endcase
    end
  end
endmodule
